control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Microprocessor controller: a 6-state T-ring plus an opcode decoder.
- Drives every datapath load and enable strobe on the 4-bit internal bus (IB), including LoadOut for the output register.
- Sits directly upstream of the output register, accumulator, B register, MAR, IR and PC. Consumes the IR opcode nibble.
- State advances on the rising edge of MainClock. Datapath registers capture on the falling edge, so each control word is stable across its capture edge.

Parameters:
- OPC_W, 4, opcode width taken from IR high nibble
- T_STATES, 6, ring length (T1..T6); fixed at 6, any other value is a synthesis error

Ports:
- MainClock  in  1  system clock; state updates on rising edge
- invMainReset  in  1  asynchronous active-low reset
- Opcode  in  OPC_W  IR opcode; valid from the end of T3
- IncPC  out  1  PC increment
- EnPC  out  1  PC drives IB
- LoadMAR  out  1  MAR loads from IB
- EnRAM  out  1  RAM drives IB
- LoadIR  out  1  IR loads from IB
- EnIR  out  1  IR operand nibble drives IB
- LoadAcc  out  1  accumulator loads from IB
- EnAcc  out  1  accumulator drives IB
- LoadB  out  1  B register loads from IB
- EnALU  out  1  ALU result drives IB
- Sub  out  1  ALU subtract select (0 = add)
- LoadOut  out  1  output register loads from IB
- Halt  out  1  processor halted
- TState  out  3  current T-state, 1..6, 0 while halted (debug)

Behaviour:
- **Reset.** invMainReset=0 forces the following immediately, regardless of clock:
  - state=T1, op_q=NOP (0110)
  - all control outputs 0, Halt=0, TState=1
  - Outputs are gated by reset, so no strobe is asserted during reset.
  - Reset mid-instruction aborts it; the first cycle after release is T1.
- **Ring.** T1→T2→T3→T4→T5→T6→T1, one state per rising edge.
- **Opcode capture.** At the rising edge leaving T3, Opcode is latched into op_q. op_q is held through T6 and ignores Opcode changes in T4..T6.
- **Opcodes:** LDA=0000, ADD=0001, SUB=0010, OUT=1110, HLT=1111. All others are NOP.
- **Control words** (outputs are a combinational decode of state and op_q; unlisted signals are 0):
  - T1: EnPC, LoadMAR
  - T2: IncPC
  - T3: EnRAM, LoadIR
  - LDA: T4 EnIR+LoadMAR; T5 EnRAM+LoadAcc; T6 idle
  - ADD: T4 EnIR+LoadMAR; T5 EnRAM+LoadB; T6 EnALU+LoadAcc
  - SUB: as ADD, with T6 = EnALU+Sub+LoadAcc
  - OUT: T4 EnAcc+LoadOut; T5, T6 idle
  - NOP: T4..T6 idle
  - HLT: the edge leaving T3 with Opcode=1111 enters HALT.
- **HALT state:**
  - Halt=1, all strobes 0, TState=0.
  - Held until reset; the clock is ignored.
- **Bus invariant.** At most one of EnPC, EnRAM, EnIR, EnAcc, EnALU is 1 in any state. Any Load* is only asserted together with exactly one En*.
- **Latency.** Every instruction is 6 cycles. LoadOut is high for exactly one cycle, the 4th cycle of the OUT instruction. The output register captures on the falling edge within that cycle.

Optional Feature:
- Macro: CTRL_EARLY_RETIRE_EN.
- Defined: idle tail states are skipped.
  - LDA returns T5→T1 (5 cycles).
  - OUT and NOP return T4→T1 (4 cycles).
  - ADD/SUB remain 6 cycles.
- Undefined: fixed 6-cycle ring for all opcodes.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode constants (OPC_LDA, OPC_ADD, OPC_SUB, OPC_OUT, OPC_HLT)
  - T-state enum (T1..T6, HALT)
  - a packed control-word struct of the 12 strobes plus a CW_IDLE constant
- Natural sub-module: tstate_ring, the ring counter with async reset, a next-state override for HALT, and early retire. control_sequencer instantiates it and adds the decode logic.

Test Plan:
- Reset: hold invMainReset=0 for 3 edges, then release → all strobes 0 during reset; first cycle EnPC=1, LoadMAR=1, TState=1.
- OUT: Opcode=1110 at the end of T3 → LoadOut=1 and EnAcc=1 only in T4; LoadOut low in all other 5 cycles. Check with the output register showing Acc value 1010 on Out3..Out0.
- ADD then SUB: check the T4..T6 strobe sequence per the table. Sub=1 only in T6 of SUB. Per-cycle assertion that at most one En* is high.
- HLT: Opcode=1111 → from cycle 4, Halt=1 and TState=0. Strobes stay 0 for 20 further clocks. A reset pulse returns to T1.
- Mid-op reset: assert invMainReset=0 during T5 of ADD → LoadB drops immediately; the sequence restarts at T1 with op_q=NOP.
- With CTRL_EARLY_RETIRE_EN: the sequence OUT, LDA, ADD takes 4+5+6=15 cycles back to T1. Without the macro it takes 18.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the microprocessor control sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ctrl_pkg;

  // Opcodes carried in the IR high nibble
  localparam logic [3:0] OPC_LDA = 4'b0000;
  localparam logic [3:0] OPC_ADD = 4'b0001;
  localparam logic [3:0] OPC_SUB = 4'b0010;
  localparam logic [3:0] OPC_NOP = 4'b0110;
  localparam logic [3:0] OPC_OUT = 4'b1110;
  localparam logic [3:0] OPC_HLT = 4'b1111;

  // Encoding matches the debug TState value: T1..T6 = 1..6, HALT = 0
  typedef enum logic [2:0] {
    ST_HALT = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_T4   = 3'd4,
    ST_T5   = 3'd5,
    ST_T6   = 3'd6
  } tstate_e;

  // One control word: every datapath strobe on the internal bus
  typedef struct packed {
    logic inc_pc;
    logic en_pc;
    logic load_mar;
    logic en_ram;
    logic load_ir;
    logic en_ir;
    logic load_acc;
    logic en_acc;
    logic load_b;
    logic en_alu;
    logic sub;
    logic load_out;
  } cw_t;

  localparam cw_t CW_IDLE = '0;

  // True for opcodes that do nothing in T4..T6 (everything not decoded)
  function automatic logic opc_is_nop(input logic [3:0] opc);
    return !(opc == OPC_LDA || opc == OPC_ADD || opc == OPC_SUB ||
             opc == OPC_OUT || opc == OPC_HLT);
  endfunction

endpackage

// File: rtl/tstate_ring.sv
// T-state ring counter T1..T6 with HALT override and early-retire return to T1.
// Latency: one state per rising clock edge; HALT entered on the edge leaving T3.
// Backpressure: none; HALT is sticky until asynchronous reset.
import ctrl_pkg::*;

module tstate_ring (
  input  logic    i_clk,
  input  logic    i_rst_n,
  input  logic    i_halt_req,
  input  logic    i_retire,
  output tstate_e o_state
);

  tstate_e r_state;
  tstate_e w_next;

  // State register; reset aborts any instruction and restarts at T1
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_T1;
    else          r_state <= w_next;
  end

  // Next state: plain ring, HALT override out of T3, early return to T1
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_T1:   w_next = ST_T2;
      ST_T2:   w_next = ST_T3;
      ST_T3:   w_next = i_halt_req ? ST_HALT : ST_T4;
      ST_T4:   w_next = ST_T5;
      ST_T5:   w_next = ST_T6;
      ST_T6:   w_next = ST_T1;
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_T1;
    endcase
    if (i_retire && r_state != ST_HALT) w_next = ST_T1;
  end

  assign o_state = r_state;

endmodule

// File: rtl/control_sequencer.sv
// Microprocessor controller: T-state ring plus opcode decode driving all IB strobes.
// Latency: 6 cycles per instruction (CTRL_EARLY_RETIRE_EN shortens LDA to 5, OUT/NOP to 4).
// Backpressure: none; HALT holds all strobes low until invMainReset.
import ctrl_pkg::*;

module control_sequencer #(
  parameter int OPC_W    = 4,
  parameter int T_STATES = 6
) (
  input  logic             MainClock,
  input  logic             invMainReset,
  input  logic [OPC_W-1:0] Opcode,
  output logic             IncPC,
  output logic             EnPC,
  output logic             LoadMAR,
  output logic             EnRAM,
  output logic             LoadIR,
  output logic             EnIR,
  output logic             LoadAcc,
  output logic             EnAcc,
  output logic             LoadB,
  output logic             EnALU,
  output logic             Sub,
  output logic             LoadOut,
  output logic             Halt,
  output logic [2:0]       TState
);

  if (T_STATES != 6) begin : g_bad_t_states
    $error("control_sequencer: T_STATES must be 6");
  end

  tstate_e          w_state;
  logic [OPC_W-1:0] r_op_q;
  logic             w_halt_req;
  logic             w_retire;
  cw_t              w_cw;
  cw_t              w_cw_out;

  assign w_halt_req = (Opcode == OPC_W'(OPC_HLT));

  tstate_ring u_ring (
    .i_clk      (MainClock),
    .i_rst_n    (invMainReset),
    .i_halt_req (w_halt_req),
    .i_retire   (w_retire),
    .o_state    (w_state)
  );

  // Latch the opcode on the edge leaving T3; held through T6
  always_ff @(posedge MainClock or negedge invMainReset) begin
    if (!invMainReset)         r_op_q <= OPC_W'(OPC_NOP);
    else if (w_state == ST_T3) r_op_q <= Opcode;
  end

  // Control word decode from state and latched opcode
  always_comb begin
    w_cw = CW_IDLE;
    case (w_state)
      ST_T1: begin w_cw.en_pc = 1'b1; w_cw.load_mar = 1'b1; end
      ST_T2: w_cw.inc_pc = 1'b1;
      ST_T3: begin w_cw.en_ram = 1'b1; w_cw.load_ir = 1'b1; end
      ST_T4: begin
        if (r_op_q == OPC_W'(OPC_LDA) || r_op_q == OPC_W'(OPC_ADD) ||
            r_op_q == OPC_W'(OPC_SUB)) begin
          w_cw.en_ir    = 1'b1;
          w_cw.load_mar = 1'b1;
        end else if (r_op_q == OPC_W'(OPC_OUT)) begin
          w_cw.en_acc   = 1'b1;
          w_cw.load_out = 1'b1;
        end
      end
      ST_T5: begin
        if (r_op_q == OPC_W'(OPC_LDA)) begin
          w_cw.en_ram   = 1'b1;
          w_cw.load_acc = 1'b1;
        end else if (r_op_q == OPC_W'(OPC_ADD) || r_op_q == OPC_W'(OPC_SUB)) begin
          w_cw.en_ram = 1'b1;
          w_cw.load_b = 1'b1;
        end
      end
      ST_T6: begin
        if (r_op_q == OPC_W'(OPC_ADD) || r_op_q == OPC_W'(OPC_SUB)) begin
          w_cw.en_alu   = 1'b1;
          w_cw.load_acc = 1'b1;
          w_cw.sub      = (r_op_q == OPC_W'(OPC_SUB));
        end
      end
      default: w_cw = CW_IDLE;
    endcase
  end

  // Early retire: skip the idle tail of LDA (after T5) and OUT/NOP (after T4)
`ifdef CTRL_EARLY_RETIRE_EN
  assign w_retire = (w_state == ST_T5 && r_op_q == OPC_W'(OPC_LDA)) ||
                    (w_state == ST_T4 && (r_op_q == OPC_W'(OPC_OUT) ||
                                          opc_is_nop(4'(r_op_q))));
`else
  assign w_retire = 1'b0;
`endif

  // Reset gates the outputs directly so no strobe leaks while it is asserted
  assign w_cw_out = invMainReset ? w_cw : CW_IDLE;
  assign Halt     = invMainReset && (w_state == ST_HALT);
  assign TState   = invMainReset ? 3'(w_state) : 3'd1;

  assign IncPC   = w_cw_out.inc_pc;
  assign EnPC    = w_cw_out.en_pc;
  assign LoadMAR = w_cw_out.load_mar;
  assign EnRAM   = w_cw_out.en_ram;
  assign LoadIR  = w_cw_out.load_ir;
  assign EnIR    = w_cw_out.en_ir;
  assign LoadAcc = w_cw_out.load_acc;
  assign EnAcc   = w_cw_out.en_acc;
  assign LoadB   = w_cw_out.load_b;
  assign EnALU   = w_cw_out.en_alu;
  assign Sub     = w_cw_out.sub;
  assign LoadOut = w_cw_out.load_out;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: reset, OUT, ADD/SUB, LDA, mid-op reset, HLT.
// Latency: expected instruction lengths follow CTRL_EARLY_RETIRE_EN.
// Backpressure: n/a.
module tb_control_sequencer;

  logic       MainClock = 1'b0;
  logic       invMainReset;
  logic [3:0] Opcode;
  logic IncPC, EnPC, LoadMAR, EnRAM, LoadIR, EnIR;
  logic LoadAcc, EnAcc, LoadB, EnALU, Sub, LoadOut, Halt;
  logic [2:0] TState;

  int n_chk = 0;
  int n_err = 0;
  int n_cyc = 0;
  logic [3:0] out_reg = 4'b0000;

  // Bit order 11..0: IncPC EnPC LoadMAR EnRAM LoadIR EnIR LoadAcc EnAcc LoadB EnALU Sub LoadOut
  localparam logic [11:0] W_IDLE  = 12'b0000_0000_0000;
  localparam logic [11:0] W_T1    = 12'b0110_0000_0000;
  localparam logic [11:0] W_T2    = 12'b1000_0000_0000;
  localparam logic [11:0] W_T3    = 12'b0001_1000_0000;
  localparam logic [11:0] W_OPND  = 12'b0010_0100_0000;
  localparam logic [11:0] W_LDACC = 12'b0001_0010_0000;
  localparam logic [11:0] W_LDB   = 12'b0001_0000_1000;
  localparam logic [11:0] W_ADD   = 12'b0000_0010_0100;
  localparam logic [11:0] W_SUB   = 12'b0000_0010_0110;
  localparam logic [11:0] W_OUT   = 12'b0000_0001_0001;

`ifdef CTRL_EARLY_RETIRE_EN
  localparam int LEN_OUT = 4;
  localparam int LEN_LDA = 5;
  localparam int LEN_NOP = 4;
  localparam int LEN_SEQ = 15;
`else
  localparam int LEN_OUT = 6;
  localparam int LEN_LDA = 6;
  localparam int LEN_NOP = 6;
  localparam int LEN_SEQ = 18;
`endif

  control_sequencer dut (
    .MainClock    (MainClock),
    .invMainReset (invMainReset),
    .Opcode       (Opcode),
    .IncPC        (IncPC),
    .EnPC         (EnPC),
    .LoadMAR      (LoadMAR),
    .EnRAM        (EnRAM),
    .LoadIR       (LoadIR),
    .EnIR         (EnIR),
    .LoadAcc      (LoadAcc),
    .EnAcc        (EnAcc),
    .LoadB        (LoadB),
    .EnALU        (EnALU),
    .Sub          (Sub),
    .LoadOut      (LoadOut),
    .Halt         (Halt),
    .TState       (TState)
  );

  always #5 MainClock = ~MainClock;

  // Output register model: captures accumulator value 1010 on the falling edge
  always @(negedge MainClock) if (LoadOut === 1'b1) out_reg <= 4'b1010;

  function automatic logic [11:0] word();
    return {IncPC, EnPC, LoadMAR, EnRAM, LoadIR, EnIR, LoadAcc, EnAcc, LoadB, EnALU, Sub, LoadOut};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge MainClock);
    #1;
    n_cyc++;
  endtask

  // Bus rules: at most one driver, and any load has exactly one driver
  task automatic chk_bus();
    int n_en;
    logic any_ld;
    n_en   = int'(EnPC) + int'(EnRAM) + int'(EnIR) + int'(EnAcc) + int'(EnALU);
    any_ld = LoadMAR | LoadIR | LoadAcc | LoadB | LoadOut;
    chk("bus_one_driver", 16'(n_en <= 1), 16'd1);
    if (any_ld) chk("bus_load_has_driver", 16'(n_en), 16'd1);
  endtask

  // Runs n cycles of one instruction from T1, checking strobes and TState each cycle
  task automatic run_instr(input string tag, input logic [3:0] opc, input int n,
                           input logic [11:0] e4, input logic [11:0] e5, input logic [11:0] e6);
    logic [11:0] exp;
    for (int k = 1; k <= n; k++) begin
      case (k)
        1: exp = W_T1;
        2: exp = W_T2;
        3: exp = W_T3;
        4: exp = e4;
        5: exp = e5;
        default: exp = e6;
      endcase
      chk({tag, "_word"}, 16'(word()), 16'(exp));
      chk({tag, "_tstate"}, 16'(TState), 16'(k));
      chk({tag, "_halt"}, 16'(Halt), 16'd0);
      chk_bus();
      if (k == 3) Opcode = opc;
      if (k == 4) Opcode = 4'b1111;  // must be ignored after T3
      tick();
    end
  endtask

  initial begin
    int c0;
    invMainReset = 1'b0;
    Opcode       = 4'b0000;

    // Reset held for three edges
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_word", 16'(word()), 16'(W_IDLE));
      chk("rst_tstate", 16'(TState), 16'd1);
      chk("rst_halt", 16'(Halt), 16'd0);
    end
    invMainReset = 1'b1;
    #1;
    chk("out_reg_before", 16'(out_reg), 16'd0);

    // OUT, LDA, ADD back-to-back, timing the round trip to T1
    c0 = n_cyc;
    run_instr("out", 4'b1110, LEN_OUT, W_OUT, W_IDLE, W_IDLE);
    chk("out_reg_after", 16'(out_reg), 16'b1010);
    run_instr("lda", 4'b0000, LEN_LDA, W_OPND, W_LDACC, W_IDLE);
    run_instr("add", 4'b0001, 6, W_OPND, W_LDB, W_ADD);
    chk("seq_cycles", 16'(n_cyc - c0), 16'(LEN_SEQ));
    chk("seq_back_t1", 16'(TState), 16'd1);

    // SUB: only instruction that raises Sub, in T6
    run_instr("sub", 4'b0010, 6, W_OPND, W_LDB, W_SUB);
    // Undecoded opcode behaves as NOP
    run_instr("nop", 4'b0101, LEN_NOP, W_IDLE, W_IDLE, W_IDLE);

    // Mid-op reset during T5 of ADD
    run_instr("add_part", 4'b0001, 4, W_OPND, W_LDB, W_ADD);
    chk("midrst_t5_word", 16'(word()), 16'(W_LDB));
    chk("midrst_t5_tstate", 16'(TState), 16'd5);
    invMainReset = 1'b0;
    #1;
    chk("midrst_loadb_drop", 16'(LoadB), 16'd0);
    chk("midrst_word", 16'(word()), 16'(W_IDLE));
    chk("midrst_tstate", 16'(TState), 16'd1);
    tick();
    chk("midrst_hold_word", 16'(word()), 16'(W_IDLE));
    invMainReset = 1'b1;
    #1;
    run_instr("post_rst_nop", 4'b0110, LEN_NOP, W_IDLE, W_IDLE, W_IDLE);

    // HLT: halted from cycle 4, ignoring the clock for 21 cycles
    run_instr("hlt", 4'b1111, 3, W_IDLE, W_IDLE, W_IDLE);
    Opcode = 4'b0001;
    for (int i = 0; i < 21; i++) begin
      chk("halt_flag", 16'(Halt), 16'd1);
      chk("halt_tstate", 16'(TState), 16'd0);
      chk("halt_word", 16'(word()), 16'(W_IDLE));
      tick();
    end
    invMainReset = 1'b0;
    #2;
    chk("halt_rst_flag", 16'(Halt), 16'd0);
    chk("halt_rst_tstate", 16'(TState), 16'd1);
    invMainReset = 1'b1;
    #1;
    run_instr("lda_after_halt", 4'b0000, LEN_LDA, W_OPND, W_LDACC, W_IDLE);
    chk("final_tstate", 16'(TState), 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
